// File: rtl/clock_time_core.sv
`timescale 1ns/1ps
// Purpose: 24-hour BCD timekeeping with a 1 Hz tick synchroniser/edge detector and a RUN/SET_HOUR/SET_MIN adjust FSM.
// Latency: a rising sec_in sampled at edge E0 updates sec_bcd and pulses sec_tick at edge E2; key pulses act on the edge that samples them.
// Backpressure: none; ticks arriving outside RUN are discarded, and key_inc is dropped when key_mode arrives in the same cycle.
module clock_time_core #(
    parameter logic [7:0] INIT_HOUR = 8'h00,
    parameter logic [7:0] INIT_MIN  = 8'h00
) (
    input  logic       clk_in_50M,
    input  logic       rst_n,
    input  logic       sec_in,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] hour_bcd,
    output logic [1:0] mode,
    output logic       sec_tick,
    output logic       day_tick
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10
    } mode_e;

    mode_e      mode_q, mode_d;
    logic       s1_q, s1_d;
    logic       s2_q, s2_d;
    logic       s3_q, s3_d;
    logic [7:0] sec_q, sec_d;
    logic [7:0] min_q, min_d;
    logic [7:0] hour_q, hour_d;
    logic       sec_tick_q, sec_tick_d;
    logic       day_tick_q, day_tick_d;
    logic       tick;

    // BCD increment that wraps to 00 once the field reaches its top value.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        logic [7:0] r;
        if (v == top) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Rising edge of the synchronised seconds signal; s3 is the previous s2.
    assign tick = s2_q & ~s3_q;

    // Synchroniser chain: s1 is the metastability stage, s2 the clean copy, s3 the edge reference.
    always_comb begin
        s1_d = sec_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // Next-state for the time fields, the mode FSM and the tick outputs.
    always_comb begin
        mode_d     = mode_q;
        sec_d      = sec_q;
        min_d      = min_q;
        hour_d     = hour_q;
        sec_tick_d = 1'b0;
        day_tick_d = 1'b0;
        case (mode_q)
            RUN: begin
                // A tick is counted even when key_mode leaves RUN on the same edge.
                if (tick) begin
                    sec_tick_d = 1'b1;
                    sec_d      = bcd_inc(sec_q, 8'h59);
                    if (sec_q == 8'h59) begin
                        min_d = bcd_inc(min_q, 8'h59);
                        if (min_q == 8'h59) begin
                            hour_d     = bcd_inc(hour_q, 8'h23);
                            day_tick_d = (hour_q == 8'h23);
                        end
                    end
                end
                if (key_mode) begin
                    mode_d = SET_HOUR;
                end
            end
            SET_HOUR: begin
                if (key_mode) begin
                    mode_d = SET_MIN;
                end else if (key_inc) begin
                    hour_d = bcd_inc(hour_q, 8'h23);
                end
            end
            SET_MIN: begin
                // Leaving the set sequence restarts the minute at :00.
                if (key_mode) begin
                    mode_d = RUN;
                    sec_d  = 8'h00;
                end else if (key_inc) begin
                    min_d = bcd_inc(min_q, 8'h59);
                end
            end
            default: begin
                mode_d = RUN;
            end
        endcase
    end

    // State registers, all cleared asynchronously so a pending sync edge is discarded on reset.
    always_ff @(posedge clk_in_50M or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            mode_q     <= RUN;
            sec_q      <= 8'h00;
            min_q      <= INIT_MIN;
            hour_q     <= INIT_HOUR;
            sec_tick_q <= 1'b0;
            day_tick_q <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            mode_q     <= mode_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            sec_tick_q <= sec_tick_d;
            day_tick_q <= day_tick_d;
        end
    end

    assign sec_bcd  = sec_q;
    assign min_bcd  = min_q;
    assign hour_bcd = hour_q;
    assign mode     = mode_q;
    assign sec_tick = sec_tick_q;
    assign day_tick = day_tick_q;

endmodule

// File: tb/tb_clock_time_core.sv
`timescale 1ns/1ps
// Bench for clock_time_core: directed key/seconds sequences checked every cycle against
// an integer time-of-day model, plus literal expectations at the interesting points.
module tb_clock_time_core;

    logic       clk;
    logic       rst_n;
    logic       sec_in;
    logic       key_mode;
    logic       key_inc;
    logic [7:0] sec_bcd;
    logic [7:0] min_bcd;
    logic [7:0] hour_bcd;
    logic [1:0] mode;
    logic       sec_tick;
    logic       day_tick;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    clock_time_core #(
        .INIT_HOUR(8'h12),
        .INIT_MIN (8'h34)
    ) dut (
        .clk_in_50M(clk),
        .rst_n     (rst_n),
        .sec_in    (sec_in),
        .key_mode  (key_mode),
        .key_inc   (key_inc),
        .sec_bcd   (sec_bcd),
        .min_bcd   (min_bcd),
        .hour_bcd  (hour_bcd),
        .mode      (mode),
        .sec_tick  (sec_tick),
        .day_tick  (day_tick)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    // Reference model: plain integer hours/minutes/seconds. A second is accepted at
    // edge n when sec_in was sampled low at edge n-3 and high at edge n-2.
    int       m_sec, m_min, m_hour, m_mode;
    bit       m_st, m_dt;
    bit [3:0] hist;

    always @(posedge clk or negedge rst_n) begin
        int s, m, h, md;
        bit st, dt, tk;
        if (!rst_n) begin
            m_sec  <= 0;
            m_min  <= 34;
            m_hour <= 12;
            m_mode <= 0;
            m_st   <= 0;
            m_dt   <= 0;
            hist   <= '0;
        end else begin
            s  = m_sec;
            m  = m_min;
            h  = m_hour;
            md = m_mode;
            st = 0;
            dt = 0;
            tk = hist[1] && !hist[2];
            if (m_mode == 0 && tk) begin
                st = 1;
                s  = s + 1;
                if (s == 60) begin
                    s = 0;
                    m = m + 1;
                    if (m == 60) begin
                        m = 0;
                        h = h + 1;
                        if (h == 24) begin
                            h  = 0;
                            dt = 1;
                        end
                    end
                end
            end
            if (key_mode) begin
                md = (m_mode + 1) % 3;
                if (m_mode == 2) s = 0;
            end else if (key_inc) begin
                if (m_mode == 1) h = (h + 1) % 24;
                else if (m_mode == 2) m = (m + 1) % 60;
            end
            m_sec  <= s;
            m_min  <= m;
            m_hour <= h;
            m_mode <= md;
            m_st   <= st;
            m_dt   <= dt;
            hist   <= {hist[2:0], sec_in};
        end
    end

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model sec",      sec_bcd,         to_bcd(m_sec));
            chk("model min",      min_bcd,         to_bcd(m_min));
            chk("model hour",     hour_bcd,        to_bcd(m_hour));
            chk("model mode",     {6'd0, mode},    8'(m_mode));
            chk("model sec_tick", {7'd0, sec_tick}, {7'd0, m_st});
            chk("model day_tick", {7'd0, day_tick}, {7'd0, m_dt});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_mode();
        key_mode = 1'b1;
        cyc(1);
        key_mode = 1'b0;
    endtask

    task automatic press_inc(input int n);
        repeat (n) begin
            key_inc = 1'b1;
            cyc(1);
            key_inc = 1'b0;
            cyc(1);
        end
    endtask

    task automatic sec_pulse(input int n);
        repeat (n) begin
            sec_in = 1'b1;
            cyc(3);
            sec_in = 1'b0;
            cyc(3);
        end
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        rst_n    = 1'b1;
        sec_in   = 1'b0;
        key_mode = 1'b0;
        key_inc  = 1'b0;
        #2 rst_n = 1'b0;
        #3;
        chk("rst hour", hour_bcd, 8'h12);
        chk("rst min",  min_bcd,  8'h34);
        chk("rst sec",  sec_bcd,  8'h00);
        chk("rst mode", {6'd0, mode}, 8'h00);
        chk("rst sec_tick", {7'd0, sec_tick}, 8'h00);
        chk("rst day_tick", {7'd0, day_tick}, 8'h00);
        chk_en = 1;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        // First-second latency: E0, E1 quiet, update after E2, tick lasts one cycle.
        sec_in = 1'b1;
        cyc(1);
        chk("lat E0 tick", {7'd0, sec_tick}, 8'h00);
        cyc(1);
        chk("lat E1 tick", {7'd0, sec_tick}, 8'h00);
        chk("lat E1 sec",  sec_bcd, 8'h00);
        cyc(1);
        chk("lat E2 sec",  sec_bcd, 8'h01);
        chk("lat E2 tick", {7'd0, sec_tick}, 8'h01);
        cyc(1);
        chk("lat tick one cycle", {7'd0, sec_tick}, 8'h00);
        sec_in = 1'b0;
        cyc(3);

        // SET_HOUR: wrap 23 -> 00 without day_tick, ticks ignored.
        press_mode();
        chk("set mode 01", {6'd0, mode}, 8'h01);
        press_inc(10);
        chk("hour 22", hour_bcd, 8'h22);
        press_inc(1);
        chk("hour 23", hour_bcd, 8'h23);
        press_inc(1);
        chk("hour wrap 00", hour_bcd, 8'h00);
        sec_pulse(2);
        chk("sec held in set", sec_bcd, 8'h01);
        press_inc(22);
        chk("hour back to 22", hour_bcd, 8'h22);
        press_inc(1);
        chk("hour 23 again", hour_bcd, 8'h23);

        // SET_MIN: wrap 59 -> 00 without carry into hour, then preset 59.
        press_mode();
        chk("set mode 10", {6'd0, mode}, 8'h02);
        press_inc(25);
        chk("min 59", min_bcd, 8'h59);
        press_inc(1);
        chk("min wrap 00", min_bcd, 8'h00);
        chk("min wrap hour", hour_bcd, 8'h23);
        press_inc(59);
        press_mode();
        chk("exit mode 00", {6'd0, mode}, 8'h00);
        chk("exit sec 00", sec_bcd, 8'h00);

        // Carry chain up to the day rollover.
        sec_pulse(9);
        chk("sec 09", sec_bcd, 8'h09);
        sec_pulse(1);
        chk("sec 10", sec_bcd, 8'h10);
        sec_pulse(9);
        chk("sec 19", sec_bcd, 8'h19);
        sec_pulse(1);
        chk("sec 20", sec_bcd, 8'h20);
        sec_pulse(39);
        chk("pre-roll sec",  sec_bcd,  8'h59);
        chk("pre-roll min",  min_bcd,  8'h59);
        chk("pre-roll hour", hour_bcd, 8'h23);
        sec_in = 1'b1;
        cyc(3);
        chk("roll sec",  sec_bcd,  8'h00);
        chk("roll min",  min_bcd,  8'h00);
        chk("roll hour", hour_bcd, 8'h00);
        chk("roll day_tick", {7'd0, day_tick}, 8'h01);
        chk("roll sec_tick", {7'd0, sec_tick}, 8'h01);
        sec_in = 1'b0;
        cyc(1);
        chk("day_tick one cycle", {7'd0, day_tick}, 8'h00);
        cyc(2);

        // Walking through the set modes clears seconds on the way back to RUN.
        sec_pulse(37);
        chk("sec 37", sec_bcd, 8'h37);
        press_mode();
        chk("walk mode 01", {6'd0, mode}, 8'h01);
        press_mode();
        chk("walk mode 10", {6'd0, mode}, 8'h02);
        chk("walk sec kept", sec_bcd, 8'h37);
        press_mode();
        chk("walk mode 00", {6'd0, mode}, 8'h00);
        chk("walk sec cleared", sec_bcd, 8'h00);

        // key_mode and key_inc together: mode wins, increment dropped.
        key_mode = 1'b1;
        key_inc  = 1'b1;
        cyc(1);
        key_mode = 1'b0;
        key_inc  = 1'b0;
        chk("collide mode", {6'd0, mode}, 8'h01);
        chk("collide hour", hour_bcd, 8'h00);
        press_mode();
        press_mode();

        // Tick and key_mode on the same edge at 00:00:59.
        sec_pulse(59);
        chk("pre-collide sec", sec_bcd, 8'h59);
        sec_in = 1'b1;
        cyc(2);
        key_mode = 1'b1;
        cyc(1);
        key_mode = 1'b0;
        chk("tick+mode sec",  sec_bcd, 8'h00);
        chk("tick+mode min",  min_bcd, 8'h01);
        chk("tick+mode mode", {6'd0, mode}, 8'h01);
        sec_in = 1'b0;
        cyc(3);

        // Reset between E0 and E2 while in SET_MIN discards the pending edge.
        press_mode();
        chk("pre-reset mode", {6'd0, mode}, 8'h02);
        sec_in = 1'b1;
        cyc(1);
        #5 rst_n = 1'b0;
        #2;
        chk("async hour", hour_bcd, 8'h12);
        chk("async min",  min_bcd,  8'h34);
        chk("async sec",  sec_bcd,  8'h00);
        chk("async mode", {6'd0, mode}, 8'h00);
        sec_in = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(6);
        chk("no stale tick", sec_bcd, 8'h00);

        // Reset with sec_in held high: exactly one tick, three edges after release.
        sec_in = 1'b1;
        #5 rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        chk("held edge2 tick", {7'd0, sec_tick}, 8'h00);
        cyc(1);
        chk("held edge3 sec",  sec_bcd, 8'h01);
        chk("held edge3 tick", {7'd0, sec_tick}, 8'h01);
        cyc(10);
        chk("held single tick", sec_bcd, 8'h01);
        sec_in = 1'b0;
        cyc(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
